instruction_cache: RTL and testbench

//  Direct-mapped, read-only instruction cache between the CPU fetch port (PC -> INSTRUCTION) and a

---
 rtl/instruction_cache_if.sv | 34 +++
 rtl/instruction_cache.sv | 119 +++++++++++
 tb/tb_instruction_cache.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/instruction_cache_if.sv
// Fetch-side and memory-side signal bundle for the instruction cache.
interface instruction_cache_if #(
  parameter int unsigned ADDR_W = 10
) ();
  logic [31:0]       PC;
  logic [31:0]       INSTRUCTION;
  logic              BUSYWAIT;
  logic              MEM_READ;
  logic [ADDR_W-5:0] MEM_ADDRESS;
  logic [127:0]      MEM_READDATA;
  logic              MEM_BUSYWAIT;

  // Cache side
  modport slave (
    input  PC,
    input  MEM_READDATA,
    input  MEM_BUSYWAIT,
    output INSTRUCTION,
    output BUSYWAIT,
    output MEM_READ,
    output MEM_ADDRESS
  );

  // CPU / memory environment side
  modport master (
    output PC,
    output MEM_READDATA,
    output MEM_BUSYWAIT,
    input  INSTRUCTION,
    input  BUSYWAIT,
    input  MEM_READ,
    input  MEM_ADDRESS
  );
endinterface

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache with 16-byte lines and a single-block refill FSM.
module instruction_cache #(
  parameter int unsigned NUM_BLOCKS = 8,
  parameter int unsigned ADDR_W     = 10
) (
  input  logic                CLK,
  input  logic                RESET,
  instruction_cache_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(NUM_BLOCKS);
  localparam int unsigned TAG_W = ADDR_W - 4 - IDX_W;
  localparam int unsigned BLK_W = ADDR_W - 4;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_UPDATE = 2'd2;

  logic [1:0]            r_state;
  logic [NUM_BLOCKS-1:0] r_valid;
  logic [TAG_W-1:0]      r_tag  [NUM_BLOCKS];
  logic [127:0]          r_data [NUM_BLOCKS];
  logic [BLK_W-1:0]      r_fetch_blk;
  logic                  r_first;
  logic [127:0]          r_line_buf;

  logic [1:0]       w_offset;
  logic [IDX_W-1:0] w_index;
  logic [TAG_W-1:0] w_tag;
  logic             w_hit;
  logic [127:0]     w_line;
  logic [31:0]      w_word;
  logic [IDX_W-1:0] w_fill_idx;
  logic [TAG_W-1:0] w_fill_tag;
  logic             w_fill;
  logic             w_unused_pc;

  assign w_offset   = bus.PC[3:2];
  assign w_index    = bus.PC[3+IDX_W:4];
  assign w_tag      = bus.PC[ADDR_W-1:4+IDX_W];
  assign w_line     = r_data[w_index];
  assign w_word     = w_line[{w_offset, 5'b0} +: 32];
  assign w_hit      = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_fill_idx = r_fetch_blk[IDX_W-1:0];
  assign w_fill_tag = r_fetch_blk[BLK_W-1:IDX_W];
  // A reset in the UPDATE cycle aborts the refill, so the line must not be written.
  assign w_fill     = (r_state == S_UPDATE) && !RESET;
  // Byte-lane and out-of-space PC bits are deliberately ignored (addresses alias).
  assign w_unused_pc = ^{bus.PC[31:ADDR_W], bus.PC[1:0]};

  // Control state: FSM, valid bits, refill block address and captured block.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= S_IDLE;
      r_valid     <= '0;
      r_fetch_blk <= '0;
      r_first     <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (!w_hit) begin
            r_fetch_blk <= bus.PC[ADDR_W-1:4];
            r_first     <= 1'b1;
            r_state     <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_first <= 1'b0;
          // The request is visible for at least one cycle before data is accepted.
          if (!r_first && !bus.MEM_BUSYWAIT) begin
            r_line_buf <= bus.MEM_READDATA;
            r_state    <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          r_valid[w_fill_idx] <= 1'b1;
          r_state             <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Line storage: tag and data are never cleared, only the valid bits are.
  always_ff @(posedge CLK) begin
    if (w_fill) begin
      r_data[w_fill_idx] <= r_line_buf;
      r_tag[w_fill_idx]  <= w_fill_tag;
    end
  end

  // Outputs: hit data in IDLE, stall otherwise; everything quiet while in reset.
  always_comb begin
    bus.INSTRUCTION = 32'd0;
    bus.BUSYWAIT    = 1'b0;
    bus.MEM_READ    = 1'b0;
    bus.MEM_ADDRESS = '0;
    if (!RESET) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            bus.INSTRUCTION = w_word;
          end else begin
            bus.BUSYWAIT = 1'b1;
          end
        end
        S_FETCH: begin
          bus.BUSYWAIT    = 1'b1;
          bus.MEM_READ    = 1'b1;
          bus.MEM_ADDRESS = r_fetch_blk;
        end
        default: begin
          bus.BUSYWAIT = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_cache.sv
// Directed self-checking bench for instruction_cache with a 5-busy-cycle block memory model.
module tb_instruction_cache;

  logic CLK;
  logic RESET;
  int   n_cmp;
  int   n_err;
  int   mem_cnt;

  logic [31:0] mem_w [256];
  logic [7:0]  mem_base;

  instruction_cache_if #(.ADDR_W(10)) bus ();

  instruction_cache #(
    .NUM_BLOCKS(8),
    .ADDR_W(10)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory model: busy for 5 cycles after MEM_READ rises, then ready.
  always @(posedge CLK) begin
    if (!bus.MEM_READ) mem_cnt <= 0;
    else if (mem_cnt < 5) mem_cnt <= mem_cnt + 1;
  end
  assign bus.MEM_BUSYWAIT = (mem_cnt < 5);
  assign mem_base = {bus.MEM_ADDRESS, 2'b00};
  assign bus.MEM_READDATA = {mem_w[mem_base | 8'd3], mem_w[mem_base | 8'd2],
                             mem_w[mem_base | 8'd1], mem_w[mem_base]};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Presents pc0, switches to pc1 after the first stalled edge, and measures the stall.
  task automatic run_access(input logic [31:0] pc0, input logic [31:0] pc1,
                            output int busy, output int reads, output logic [31:0] last_addr);
    logic prev_read;
    bus.PC = pc0;
    #1;
    busy = 0;
    reads = 0;
    last_addr = 0;
    prev_read = 1'b0;
    for (int c = 0; c < 60 && bus.BUSYWAIT; c++) begin
      busy++;
      if (bus.MEM_READ && !prev_read) begin
        reads++;
        last_addr = 32'(bus.MEM_ADDRESS);
      end
      prev_read = bus.MEM_READ;
      tick();
      if (c == 0) begin
        bus.PC = pc1;
        #1;
      end
    end
  endtask

  // Single-PC access with expected stall length, reads, block address and instruction.
  task automatic access(input string tag, input logic [31:0] pc, input int exp_busy,
                        input int exp_reads, input logic [31:0] exp_addr,
                        input logic [31:0] exp_instr);
    int busy;
    int reads;
    logic [31:0] addr;
    run_access(pc, pc, busy, reads, addr);
    check_eq({tag, ".busy"}, 32'(busy), 32'(exp_busy));
    check_eq({tag, ".reads"}, 32'(reads), 32'(exp_reads));
    if (exp_reads > 0) check_eq({tag, ".addr"}, addr, exp_addr);
    check_eq({tag, ".instr"}, bus.INSTRUCTION, exp_instr);
    check_eq({tag, ".memrd"}, 32'(bus.MEM_READ), 32'd0);
    check_eq({tag, ".memaddr"}, 32'(bus.MEM_ADDRESS), 32'd0);
    tick();
  endtask

  initial begin
    int busy;
    int reads;
    logic [31:0] addr;
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) mem_w[i] = 32'hA000_0000 | i;
    mem_w[0] = 32'h11;
    mem_w[1] = 32'h22;
    mem_w[2] = 32'h33;
    mem_w[3] = 32'h44;

    // T1: reset holds outputs quiet, then a cold miss appears.
    RESET = 1'b1;
    bus.PC = 32'h0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("rst.busy", 32'(bus.BUSYWAIT), 32'd0);
      check_eq("rst.memrd", 32'(bus.MEM_READ), 32'd0);
      check_eq("rst.instr", bus.INSTRUCTION, 32'd0);
      check_eq("rst.memaddr", 32'(bus.MEM_ADDRESS), 32'd0);
    end
    RESET = 1'b0;
    #1;
    check_eq("cold.busy", 32'(bus.BUSYWAIT), 32'd1);

    // T2: cold miss, 5 busy memory cycles -> 8 stalled cycles.
    access("t2", 32'h000, 8, 1, 32'h0, 32'h11);

    // T3: spatial hits in the same line, plus an aliased upper PC bit.
    access("t3a", 32'h004, 0, 0, 32'h0, 32'h22);
    access("t3b", 32'h008, 0, 0, 32'h0, 32'h33);
    access("t3c", 32'h00C, 0, 0, 32'h0, 32'h44);
    access("t3alias", 32'h0000_040D, 0, 0, 32'h0, 32'h44);

    // T4: conflict on index 0 evicts block 0.
    access("t4a", 32'h080, 8, 1, 32'h08, 32'hA000_0020);
    access("t4b", 32'h000, 8, 1, 32'h00, 32'h11);

    // T5: reset in the third FETCH cycle aborts the refill and clears valid bits.
    bus.PC = 32'h010;
    #1;
    tick();
    tick();
    tick();
    check_eq("t5.memrd_pre", 32'(bus.MEM_READ), 32'd1);
    check_eq("t5.addr_pre", 32'(bus.MEM_ADDRESS), 32'h1);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    #1;
    check_eq("t5.memrd_post", 32'(bus.MEM_READ), 32'd0);
    check_eq("t5.busy_post", 32'(bus.BUSYWAIT), 32'd1);
    access("t5a", 32'h010, 8, 1, 32'h01, 32'hA000_0004);
    access("t5b", 32'h000, 8, 1, 32'h00, 32'h11);

    // T6a: PC moves to another word of the block being filled -> no second read.
    run_access(32'h020, 32'h024, busy, reads, addr);
    check_eq("t6a.busy", 32'(busy), 32'd8);
    check_eq("t6a.reads", 32'(reads), 32'd1);
    check_eq("t6a.instr", bus.INSTRUCTION, 32'hA000_0009);
    tick();

    // T6b: after invalidating, PC moves to a different block -> second refill.
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    run_access(32'h020, 32'h040, busy, reads, addr);
    check_eq("t6b.busy", 32'(busy), 32'd16);
    check_eq("t6b.reads", 32'(reads), 32'd2);
    check_eq("t6b.addr", addr, 32'h04);
    check_eq("t6b.instr", bus.INSTRUCTION, 32'hA000_0010);
    tick();
    access("t6b.hit20", 32'h020, 0, 0, 32'h0, 32'hA000_0008);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
